// File: rtl/lif_pkg.sv
// Shared types and width helpers for the LIF neuron scheduler slice.
package lif_pkg;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ISSUE   = 2'd1,
        S_CAPTURE = 2'd2,
        S_DONE    = 2'd3
    } lif_state_e;

    // Datapath is two bits wider than the stage count (sign plus headroom).
    localparam int unsigned LIF_W_EXTRA = 2;

    function automatic int unsigned lif_width(input int unsigned n_stage);
        return n_stage + LIF_W_EXTRA;
    endfunction

    function automatic int unsigned lif_idx_width(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/lif_membrane_rf.sv
// Membrane potential storage: DEPTH x W, one async read port, one sync write port.
module lif_membrane_rf
    import lif_pkg::*;
#(
    parameter int unsigned W     = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            we_i,
    input  logic [lif_idx_width(DEPTH)-1:0] waddr_i,
    input  logic [W-1:0]                    wdata_i,
    input  logic [lif_idx_width(DEPTH)-1:0] raddr_i,
    output logic [W-1:0]                    rd_data_c
);

    logic [W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rd_data_c = mem_q[raddr_i];

endmodule

// File: rtl/lif_neuron_scheduler.sv
// Time-multiplexes NUM_NEURONS LIF neurons over one external accumulator.
// Optional refractory counters are enabled with `define LIF_REFRACTORY_EN.
module lif_neuron_scheduler
    import lif_pkg::*;
#(
    parameter int unsigned N_STAGE     = 6,
    parameter int unsigned NUM_NEURONS = 4,
    parameter int unsigned BETA_SHIFT  = 1
`ifdef LIF_REFRACTORY_EN
    ,
    parameter int unsigned REFRACT_STEPS = 1
`endif
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 step_valid,
    output logic                                 step_ready,
    input  logic [(N_STAGE+2)*NUM_NEURONS-1:0]   sum_wx,
    input  logic [N_STAGE+1:0]                   threshold,
    output logic [NUM_NEURONS-1:0]               spikes,
    output logic                                 done,
    output logic [N_STAGE+1:0]                   acc_beta_u,
    output logic [N_STAGE+1:0]                   acc_sum_wx,
    output logic [N_STAGE+1:0]                   acc_minus_teta,
    output logic                                 acc_was_spike,
    input  logic [N_STAGE+1:0]                   acc_u_out
);

    localparam int unsigned W    = lif_width(N_STAGE);
    localparam int unsigned IDXW = lif_idx_width(NUM_NEURONS);
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NUM_NEURONS - 1);

    lif_state_e                      state_q, state_d;
    logic [IDXW-1:0]                 idx_q, idx_d;
    logic [W*NUM_NEURONS-1:0]        sum_wx_q, sum_wx_d;
    logic [W-1:0]                    theta_q, theta_d;
    logic [NUM_NEURONS-1:0]          spikes_q, spikes_d;
    logic [NUM_NEURONS-1:0]          spike_next_q, spike_next_d;
    logic                            done_q, done_d;
    logic                            ready_q, ready_d;
    logic [W-1:0]                    beta_q, beta_d;
    logic [W-1:0]                    accsum_q, accsum_d;
    logic [W-1:0]                    teta_q, teta_d;
    logic                            ws_q, ws_d;

    logic                            u_we;
    logic [W-1:0]                    u_wdata;
    logic [W-1:0]                    u_rd;
    logic                            new_spike;
    logic                            in_refr;

    // Read port follows the next index so acc_* can be registered on entry to ISSUE.
    lif_membrane_rf #(
        .W     (W),
        .DEPTH (NUM_NEURONS)
    ) u_rf (
        .clk       (clk),
        .rst_n     (rst_n),
        .we_i      (u_we),
        .waddr_i   (idx_q),
        .wdata_i   (u_wdata),
        .raddr_i   (idx_d),
        .rd_data_c (u_rd)
    );

`ifdef LIF_REFRACTORY_EN
    localparam int unsigned CNTW = lif_idx_width(REFRACT_STEPS + 1);

    logic [CNTW-1:0] refr_q [NUM_NEURONS];
    logic [CNTW-1:0] refr_d [NUM_NEURONS];
    logic            step_done_c;

    assign in_refr     = (refr_q[idx_q] != '0);
    assign step_done_c = (state_q == S_CAPTURE) && (idx_q == LAST_IDX);

    // A fresh spike reloads the counter; otherwise it counts down once per completed step.
    always_comb begin
        for (int i = 0; i < int'(NUM_NEURONS); i++) begin
            refr_d[i] = refr_q[i];
            if (step_done_c) begin
                if (spikes_d[i]) begin
                    refr_d[i] = CNTW'(REFRACT_STEPS);
                end else if (refr_q[i] != '0) begin
                    refr_d[i] = refr_q[i] - CNTW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(NUM_NEURONS); i++) begin
                refr_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < int'(NUM_NEURONS); i++) begin
                refr_q[i] <= refr_d[i];
            end
        end
    end
`else
    assign in_refr = 1'b0;
`endif

    // Next-state, capture and accumulator-drive logic.
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        sum_wx_d     = sum_wx_q;
        theta_d      = theta_q;
        spikes_d     = spikes_q;
        spike_next_d = spike_next_q;
        beta_d       = beta_q;
        accsum_d     = accsum_q;
        teta_d       = teta_q;
        ws_d         = ws_q;
        u_we         = 1'b0;
        u_wdata      = acc_u_out;
        new_spike    = ($signed(acc_u_out) >= $signed(theta_q));

        if (in_refr) begin
            u_wdata   = '0;
            new_spike = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                if (step_valid && ready_q) begin
                    sum_wx_d     = sum_wx;
                    theta_d      = threshold;
                    idx_d        = '0;
                    spike_next_d = '0;
                    state_d      = S_ISSUE;
                end
            end
            S_ISSUE: begin
                state_d = S_CAPTURE;
            end
            S_CAPTURE: begin
                u_we                = 1'b1;
                spike_next_d[idx_q] = new_spike;
                if (idx_q == LAST_IDX) begin
                    spikes_d = spike_next_d;
                    state_d  = S_DONE;
                end else begin
                    idx_d   = idx_q + IDXW'(1);
                    state_d = S_ISSUE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        ready_d = (state_d == S_IDLE);
        done_d  = (state_d == S_DONE);

        // Operands are loaded on entry to ISSUE and held through CAPTURE.
        if (state_d == S_ISSUE) begin
            beta_d   = u_rd - W'($signed(u_rd) >>> BETA_SHIFT);
            accsum_d = sum_wx_d[int'(idx_d)*W +: W];
            teta_d   = (~theta_d) + W'(1);
            ws_d     = spikes_q[idx_d];
        end else if (state_d != S_CAPTURE) begin
            beta_d   = '0;
            accsum_d = '0;
            teta_d   = '0;
            ws_d     = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            idx_q        <= '0;
            sum_wx_q     <= '0;
            theta_q      <= '0;
            spikes_q     <= '0;
            spike_next_q <= '0;
            done_q       <= 1'b0;
            ready_q      <= 1'b1;
            beta_q       <= '0;
            accsum_q     <= '0;
            teta_q       <= '0;
            ws_q         <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            sum_wx_q     <= sum_wx_d;
            theta_q      <= theta_d;
            spikes_q     <= spikes_d;
            spike_next_q <= spike_next_d;
            done_q       <= done_d;
            ready_q      <= ready_d;
            beta_q       <= beta_d;
            accsum_q     <= accsum_d;
            teta_q       <= teta_d;
            ws_q         <= ws_d;
        end
    end

    assign step_ready     = ready_q;
    assign done           = done_q;
    assign spikes         = spikes_q;
    assign acc_beta_u     = beta_q;
    assign acc_sum_wx     = accsum_q;
    assign acc_minus_teta = teta_q;
    assign acc_was_spike  = ws_q;

endmodule
